// File: rtl/race_draw_sequencer.sv
// Pixel-draw sequencer for the racing game VGA path.
// Owns the raster counters (x_out/y_out) and the car position register.
// A full redraw paints three full-height stripes and then the car sprite.
// A move erases the old car box, steps car_x with clamping and redraws the car.
// Optional build macro VSYNC_WAIT_EN: a move first waits for vblank before erasing.
module race_draw_sequencer #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int ROAD_X0  = 30,
    parameter int ROAD_X1  = 130,
    parameter int CAR_W    = 5,
    parameter int CAR_H    = 13,
    parameter int CAR_X0   = 78,
    parameter int CAR_Y0   = 100,
    parameter int STEP     = 2
) (
    input  logic           clock,
    input  logic           resetn,
    input  logic           start,
    input  logic           move_req,
    input  logic [1:0]     move_dir,
    input  logic           vblank,
    output logic           ready,
    output logic           plot,
    output logic [X_W-1:0] x_out,
    output logic [Y_W-1:0] y_out,
    output logic [1:0]     colour_sel,
    output logic           done,
    output logic [X_W-1:0] car_x
);

    typedef enum logic [3:0] {
        S_IDLE, S_BG_LEFT, S_BG_ROAD, S_BG_RIGHT, S_CAR,
        S_DONE, S_WAIT_MOVE, S_ERASE, S_UPDATE, S_WAIT_VB
    } state_t;

    localparam logic [1:0] COL_BLACK = 2'd0;
    localparam logic [1:0] COL_GREEN = 2'd1;
    localparam logic [1:0] COL_CAR   = 2'd2;

    localparam logic [X_W-1:0] ROAD_X0_C  = X_W'(ROAD_X0);
    localparam logic [X_W-1:0] ROAD_X1_C  = X_W'(ROAD_X1);
    localparam logic [X_W-1:0] LEFT_LAST  = X_W'(ROAD_X0 - 1);
    localparam logic [X_W-1:0] ROAD_LAST  = X_W'(ROAD_X1 - 1);
    localparam logic [X_W-1:0] RIGHT_LAST = X_W'(SCREEN_W - 1);
    localparam logic [X_W-1:0] CAR_W_M1   = X_W'(CAR_W - 1);
    localparam logic [X_W-1:0] CAR_X0_C   = X_W'(CAR_X0);
    localparam logic [Y_W-1:0] SCR_Y_LAST = Y_W'(SCREEN_H - 1);
    localparam logic [Y_W-1:0] CAR_Y0_C   = Y_W'(CAR_Y0);
    localparam logic [Y_W-1:0] CAR_Y_LAST = Y_W'(CAR_Y0 + CAR_H - 1);

    // Clamp arithmetic is one bit wider so car_x - STEP cannot wrap.
    localparam logic [X_W:0] ROAD_X0_W   = (X_W+1)'(ROAD_X0);
    localparam logic [X_W:0] STEP_W      = (X_W+1)'(STEP);
    localparam logic [X_W:0] RIGHT_LIM_W = (X_W+1)'(ROAD_X1 - CAR_W);

    state_t         state;
    logic [1:0]     dir_reg;
    logic [X_W:0]   car_ext;
    logic [X_W:0]   car_sel;
    logic [X_W-1:0] car_x_next;
    logic [X_W-1:0] x_first;
    logic [X_W-1:0] x_last;
    logic [Y_W-1:0] y_last;
    logic [X_W-1:0] x_step;
    logic [Y_W-1:0] y_step;
    logic           row_end;
    logic           region_end;

`ifndef VSYNC_WAIT_EN
    // vblank has no function in this build
    logic vblank_unused;
    assign vblank_unused = vblank;
`endif

    // Next car position from the latched direction, clamped to the road.
    always_comb begin
        car_ext = {1'b0, car_x};
        car_sel = car_ext;
        if (dir_reg == 2'b01) begin
            car_sel = (car_ext < ROAD_X0_W + STEP_W) ? ROAD_X0_W : car_ext - STEP_W;
        end else if (dir_reg == 2'b10) begin
            car_sel = (car_ext + STEP_W > RIGHT_LIM_W) ? RIGHT_LIM_W : car_ext + STEP_W;
        end
        car_x_next = car_sel[X_W-1:0];
    end

    // Current region bounds and the raster step to the next pixel.
    always_comb begin
        x_first = car_x;
        x_last  = car_x + CAR_W_M1;
        y_last  = CAR_Y_LAST;
        case (state)
            S_BG_LEFT:  begin x_first = '0;        x_last = LEFT_LAST;  y_last = SCR_Y_LAST; end
            S_BG_ROAD:  begin x_first = ROAD_X0_C; x_last = ROAD_LAST;  y_last = SCR_Y_LAST; end
            S_BG_RIGHT: begin x_first = ROAD_X1_C; x_last = RIGHT_LAST; y_last = SCR_Y_LAST; end
            default:    ;
        endcase
        row_end    = (x_out == x_last);
        region_end = row_end && (y_out == y_last);
        x_step     = row_end ? x_first : x_out + X_W'(1);
        y_step     = row_end ? y_out + Y_W'(1) : y_out;
    end

    // Sequencer FSM with registered pixel, handshake and car-position outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            ready      <= 1'b1;
            plot       <= 1'b0;
            done       <= 1'b0;
            x_out      <= '0;
            y_out      <= '0;
            colour_sel <= COL_BLACK;
            car_x      <= CAR_X0_C;
            dir_reg    <= 2'b00;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_WAIT_MOVE: begin
                    if (start) begin
                        state      <= S_BG_LEFT;
                        x_out      <= '0;
                        y_out      <= '0;
                        plot       <= 1'b1;
                        colour_sel <= COL_GREEN;
                        ready      <= 1'b0;
                    end else if (move_req && state == S_WAIT_MOVE) begin
                        dir_reg <= move_dir;
                        ready   <= 1'b0;
`ifdef VSYNC_WAIT_EN
                        state   <= S_WAIT_VB;
`else
                        state      <= S_ERASE;
                        x_out      <= car_x;
                        y_out      <= CAR_Y0_C;
                        plot       <= 1'b1;
                        colour_sel <= COL_BLACK;
`endif
                    end
                end
`ifdef VSYNC_WAIT_EN
                S_WAIT_VB: begin
                    if (vblank) begin
                        state      <= S_ERASE;
                        x_out      <= car_x;
                        y_out      <= CAR_Y0_C;
                        plot       <= 1'b1;
                        colour_sel <= COL_BLACK;
                    end
                end
`endif
                S_BG_LEFT, S_BG_ROAD, S_BG_RIGHT, S_CAR, S_ERASE: begin
                    if (!region_end) begin
                        x_out <= x_step;
                        y_out <= y_step;
                    end else if (state == S_BG_LEFT) begin
                        state      <= S_BG_ROAD;
                        x_out      <= ROAD_X0_C;
                        y_out      <= '0;
                        colour_sel <= COL_BLACK;
                    end else if (state == S_BG_ROAD) begin
                        state      <= S_BG_RIGHT;
                        x_out      <= ROAD_X1_C;
                        y_out      <= '0;
                        colour_sel <= COL_GREEN;
                    end else if (state == S_BG_RIGHT) begin
                        state      <= S_CAR;
                        x_out      <= car_x;
                        y_out      <= CAR_Y0_C;
                        colour_sel <= COL_CAR;
                    end else if (state == S_CAR) begin
                        state <= S_DONE;
                        plot  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= S_UPDATE;
                        plot  <= 1'b0;
                    end
                end
                S_UPDATE: begin
                    car_x      <= car_x_next;
                    state      <= S_CAR;
                    x_out      <= car_x_next;
                    y_out      <= CAR_Y0_C;
                    plot       <= 1'b1;
                    colour_sel <= COL_CAR;
                end
                S_DONE: begin
                    state <= S_WAIT_MOVE;
                    ready <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    ready <= 1'b1;
                    plot  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_race_draw_sequencer.sv
// Scoreboard bench for race_draw_sequencer: expected pixels/done pulses are
// queued from a screen-level model; a monitor pops and compares each output.
module tb_race_draw_sequencer;

    localparam int SW = 160, SH = 120, RX0 = 30, RX1 = 130;
    localparam int CW = 5, CH = 13, CX0 = 78, CY0 = 100, STP = 2;
    localparam int REDRAW_CYC = SW * SH + CW * CH;
`ifdef VSYNC_WAIT_EN
    localparam int VB_EXTRA = 1;
`else
    localparam int VB_EXTRA = 0;
`endif
    localparam int MOVE_CYC = 2 * CW * CH + 1 + VB_EXTRA;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic       move_req = 1'b0;
    logic [1:0] move_dir = 2'b00;
    logic       vblank = 1'b1;
    logic       ready, plot, done;
    logic [7:0] x_out, car_x;
    logic [6:0] y_out;
    logic [1:0] colour_sel;

    race_draw_sequencer dut (
        .clock(clock), .resetn(resetn), .start(start), .move_req(move_req),
        .move_dir(move_dir), .vblank(vblank), .ready(ready), .plot(plot),
        .x_out(x_out), .y_out(y_out), .colour_sel(colour_sel), .done(done),
        .car_x(car_x)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit is_done;
        int x;
        int y;
        int c;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cx = CX0;

    task automatic check(input string nm, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", nm, act, expv);
        end
    endtask

    function automatic void push_px(input int x, input int y, input int c);
        exp_t e;
        e.is_done = 1'b0; e.x = x; e.y = y; e.c = c;
        q.push_back(e);
    endfunction

    function automatic void push_done();
        exp_t e;
        e.is_done = 1'b1; e.x = 0; e.y = 0; e.c = 0;
        q.push_back(e);
    endfunction

    function automatic void push_rect(input int xa, input int xb, input int ya, input int yb, input int c);
        for (int y = ya; y < yb; y++)
            for (int x = xa; x < xb; x++)
                push_px(x, y, c);
    endfunction

    // Whole screen: left verge, road, right verge, then the car.
    function automatic void push_redraw();
        push_rect(0, RX0, 0, SH, 1);
        push_rect(RX0, RX1, 0, SH, 0);
        push_rect(RX1, SW, 0, SH, 1);
        push_rect(cx, cx + CW, CY0, CY0 + CH, 2);
        push_done();
    endfunction

    function automatic void push_move(input logic [1:0] d);
        push_rect(cx, cx + CW, CY0, CY0 + CH, 0);
        if (d == 2'b01) cx = (cx - STP < RX0) ? RX0 : cx - STP;
        else if (d == 2'b10) cx = (cx + STP > RX1 - CW) ? RX1 - CW : cx + STP;
        push_rect(cx, cx + CW, CY0, CY0 + CH, 2);
        push_done();
    endfunction

    // Monitor: every plotted pixel or done pulse must match the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (resetn && (plot || done)) begin
                total++;
                if (plot && done) begin
                    bad++;
                    $display("FAIL plot_and_done both high x=%0d y=%0d", x_out, y_out);
                end else if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_output plot=%0d done=%0d x=%0d y=%0d col=%0d",
                             plot, done, x_out, y_out, colour_sel);
                end else begin
                    e = q.pop_front();
                    if (e.is_done != done ||
                        (plot && (x_out != e.x || y_out != e.y || colour_sel != e.c))) begin
                        bad++;
                        $display("FAIL scoreboard got plot=%0d done=%0d x=%0d y=%0d col=%0d expected done=%0d x=%0d y=%0d col=%0d",
                                 plot, done, x_out, y_out, colour_sel, e.is_done, e.x, e.y, e.c);
                    end
                end
            end
        end
    end

    // Drive one request; returns just after the accepting edge.
    task automatic issue(input bit s, input bit m, input logic [1:0] d);
        check("ready_before_req", ready, 1);
        start = s; move_req = m; move_dir = d;
`ifndef VSYNC_WAIT_EN
        vblank = 1'($urandom_range(0, 1));
`endif
        @(posedge clock); #1;
        start = 0; move_req = 0;
    endtask

    // Count edges until done; optionally fire an ignored request mid-sequence.
    task automatic run_wait(input int exp_cyc, input string nm, input bit garbage);
        int  n = 0;
        bit  seen = 0;
        while (n < 40000 && !seen) begin
            @(posedge clock); #1;
            n++;
            if (garbage && n == 10) begin
                {start, move_req} = 2'(1 << $urandom_range(0, 1));
                move_dir = 2'($urandom_range(0, 3));
            end
            if (n == 11) begin start = 0; move_req = 0; end
            seen = done;
        end
        check({nm, "_latency"}, seen ? n : -1, exp_cyc);
        @(posedge clock); #1;
        check({nm, "_ready_after"}, ready, 1);
        check({nm, "_car_x"}, car_x, cx);
    endtask

    task automatic do_move(input logic [1:0] d);
        push_move(d);
        issue(0, 1, d);
        run_wait(MOVE_CYC, "move", 1);
    endtask

    initial begin
        int p;
        repeat (3) @(posedge clock);
        #1;
        check("rst_ready", ready, 1);
        check("rst_plot", plot, 0);
        check("rst_done", done, 0);
        check("rst_x", x_out, 0);
        check("rst_y", y_out, 0);
        check("rst_col", colour_sel, 0);
        check("rst_car_x", car_x, CX0);
        #1 resetn = 1;
        @(posedge clock); #1;

        // full redraw from IDLE
        push_redraw();
        issue(1, 0, 2'b00);
        check("first_px_plot", plot, 1);
        run_wait(REDRAW_CYC, "redraw", 1);

        // directed right move, then random moves
        do_move(2'b10);
        check("right_from_78", car_x, 80);
        for (int i = 0; i < 20; i++) do_move(2'($urandom_range(0, 3)));

        // left clamp, including the 32 -> 30 step
        while (cx > RX0) do_move(2'b01);
        do_move(2'b10);
        do_move(2'b01);
        do_move(2'b01);
        check("left_clamp", car_x, RX0);

        // right clamp
        while (cx < RX1 - CW) do_move(2'b10);
        do_move(2'b10);
        do_move(2'b10);
        check("right_clamp", car_x, RX1 - CW);

        // start and move_req together: start wins, car_x unchanged
        push_redraw();
        issue(1, 1, 2'b01);
        run_wait(REDRAW_CYC, "start_wins", 0);

`ifdef VSYNC_WAIT_EN
        // move held off until vblank rises
        vblank = 0;
        push_move(2'b01);
        issue(0, 1, 2'b01);
        for (int i = 0; i < 40; i++) begin
            check("vb_wait_plot", plot, 0);
            check("vb_wait_ready", ready, 0);
            @(posedge clock); #1;
        end
        vblank = 1;
        check("vb_still_idle", plot, 0);
        @(posedge clock); #1;
        check("vb_first_erase", plot, 1);
        run_wait(MOVE_CYC - VB_EXTRA, "vb_move", 1);
`endif

        // reset in the middle of the road stripe
        push_redraw();
        issue(1, 0, 2'b00);
        repeat (RX0 * SH + 5000 - 1) @(posedge clock);
        #1;
        p = 5000 - 1;
        check("mid_road_plot", plot, 1);
        check("mid_road_x", x_out, RX0 + p % (RX1 - RX0));
        check("mid_road_y", y_out, p / (RX1 - RX0));
        resetn = 0;
        #1;
        check("async_rst_plot", plot, 0);
        check("async_rst_car_x", car_x, CX0);
        check("async_rst_ready", ready, 1);
        check("async_rst_done", done, 0);
        q.delete();
        cx = CX0;
        repeat (3) @(posedge clock);
        #2 resetn = 1;
        @(posedge clock); #1;
        // move_req in IDLE is ignored; the monitor flags any output
        move_req = 1; move_dir = 2'b10;
        @(posedge clock); #1;
        move_req = 0;
        repeat (30) @(posedge clock);
        #1;
        check("post_rst_ready", ready, 1);
        check("post_rst_car_x", car_x, CX0);
        check("queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
